// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - update handshake bundle for the 7-segment scanner
//
// Purpose : carries a packed hex display value from a producer to seg_scan.
// Signals : upd_value [4*DIGITS-1:0] packed nibbles, digit 0 least significant
//           upd_valid                 producer offers upd_value, held until accepted
//           upd_ready                 scanner accepts this cycle (frame boundary)
// Modports: master = producer, slave = seg_scan
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] upd_value;
  logic                upd_valid;
  logic                upd_ready;

  modport master (output upd_value, output upd_valid, input upd_ready);
  modport slave  (input upd_value, input upd_valid, output upd_ready);
endinterface

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed multi-digit 7-segment scanner
//
// Purpose : latches a packed hex value at frame boundaries only and walks the
//           digits one at a time, with a blanking gap before each digit and
//           optional leading-zero suppression.
// Ports   : clk        system clock, rising edge
//           reset      synchronous, active-high
//           upd        seg_scan_if.slave update handshake (value/valid/ready)
//           lz_en      leading-zero suppression enable
//           digit_num  nibble of the selected digit, to the hex decoder
//           digit_en   one-hot enable of the lit digit, zero while blanking
//           blank      high when no digit is lit
module seg_scan #(
  parameter int DIGITS    = 4,
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic              clk,
  input  logic              reset,
  seg_scan_if.slave         upd,
  input  logic              lz_en,
  output logic [3:0]        digit_num,
  output logic [DIGITS-1:0] digit_en,
  output logic              blank
);

  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] shadow;
  logic                supp, supp_n;
  logic                zero_above;
  logic                frame_start;
  logic                lit;

  // First BLANK cycle of digit 0 is the only point where a new value may land,
  // so a frame is always drawn from a single shadow value.
  assign frame_start   = (state == ST_BLANK) && (idx == '0) && (cnt == '0);
  assign upd.upd_ready = frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_BLANK;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      supp   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      supp  <= supp_n;
      if (frame_start && upd.upd_valid) begin
        shadow <= upd.upd_value;
      end
    end
  end

  // True when digit idx and every digit above it are zero.
  always_comb begin
    zero_above = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx)) && (shadow[4*i +: 4] != 4'd0)) begin
        zero_above = 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    supp_n  = supp;
    case (state)
      ST_BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
          // Suppression is frozen at SHOW entry so lz_en never reaches the
          // outputs combinationally and cannot flicker a digit mid-dwell.
          supp_n  = lz_en && (idx != '0) && zero_above;
        end
      end
      ST_SHOW: begin
        if (cnt == CW'(DWELL_CYC - 1)) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          idx_n   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
          supp_n  = 1'b0;
        end
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  // digit_num is presented through BLANK too so the decoder settles early.
  assign digit_num = shadow[{idx, 2'b00} +: 4];
  assign lit       = (state == ST_SHOW) && !supp;
  assign digit_en  = lit ? (DIGITS'(1) << idx) : '0;
  assign blank     = !lit;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - directed self-checking bench for seg_scan
module tb_seg_scan;
  localparam int DIGITS = 4;
  localparam int DWELL  = 6;
  localparam int BLNK   = 2;
  localparam int SLOT   = DWELL + BLNK;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lz_en = 1'b0;
  logic [3:0]  digit_num;
  logic [3:0]  digit_en;
  logic        blank;

  seg_scan_if #(.DIGITS(DIGITS)) upd ();

  seg_scan #(
    .DIGITS   (DIGITS),
    .DWELL_CYC(DWELL),
    .BLANK_CYC(BLNK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .upd      (upd),
    .lz_en    (lz_en),
    .digit_num(digit_num),
    .digit_en (digit_en),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          fc = 0;
  int          cyc = 0;
  int          last_ready = -1000;
  logic [15:0] cur = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d, frame pos %0d)", tag, obs, exp, cyc, fc);
    end
  endtask

  // Expected outputs come from the frame position: slot k = fc/SLOT,
  // first BLNK cycles of a slot blank, remaining DWELL cycles lit.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      int         slot;
      int         r;
      logic       sup;
      logic [3:0] een;
      logic [3:0] enib;
      logic       acc;
      slot = fc / SLOT;
      r    = fc % SLOT;
      sup  = lz_en && (slot > 0) && ((cur >> (4 * slot)) == 16'd0);
      een  = (r >= BLNK && !sup) ? (4'b0001 << slot) : 4'b0000;
      enib = 4'((cur >> (4 * slot)) & 16'hF);
      chk("digit_en", digit_en, een);
      chk("blank", blank, een == 4'b0000);
      chk("digit_num", digit_num, enib);
      chk("upd_ready", upd.upd_ready, fc == 0);
      chk("onehot0", $onehot0(digit_en), 1'b1);
      chk("blank_vs_en", blank, digit_en == 4'b0000);
      if (upd.upd_ready) begin
        chk("ready_gap", (cyc - last_ready) >= FRAME, 1'b1);
        last_ready = cyc;
      end
      acc = (fc == 0) && upd.upd_valid;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        cur           = upd.upd_value;
        upd.upd_valid = 1'b0;
      end
      fc = (fc + 1) % FRAME;
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_digit_en", digit_en, 4'b0000);
    chk("rst_blank", blank, 1'b1);
    chk("rst_digit_num", digit_num, 4'h0);
    chk("rst_upd_ready", upd.upd_ready, 1'b1);
    reset      = 1'b0;
    fc         = 0;
    cur        = 16'h0;
    last_ready = -1000;
  endtask

  initial begin
    int k;
    upd.upd_value = 16'h1234;
    upd.upd_valid = 1'b1;

    // Value offered from cycle 0, accepted on the first cycle after reset.
    do_reset();
    run(1);
    chk("accept_1234_valid_dropped", upd.upd_valid, 1'b0);
    run(1);
    chk("f2_digit0_lit", digit_en, 4'b0001);
    chk("f2_digit0_num", digit_num, 4'h4);
    run(FRAME - 2);

    // Mid-frame request waits for the next boundary.
    run(10);
    upd.upd_value = 16'hABCD;
    upd.upd_valid = 1'b1;
    run(FRAME - 10);
    chk("abcd_pending_at_boundary", upd.upd_valid, 1'b1);
    run(FRAME);

    // Leading-zero suppression with 0050, then disabled.
    upd.upd_value = 16'h0050;
    upd.upd_valid = 1'b1;
    lz_en = 1'b1;
    run(2 * SLOT + BLNK);
    chk("lz_digit2_dark_en", digit_en, 4'b0000);
    chk("lz_digit2_dark_blank", blank, 1'b1);
    run(FRAME - 2 * SLOT - BLNK);
    lz_en = 1'b0;
    run(FRAME);

    // All-zero value with suppression: only digit 0 lights.
    upd.upd_value = 16'h0000;
    upd.upd_valid = 1'b1;
    lz_en = 1'b1;
    run(FRAME);

    // Reset in the middle of digit 2's SHOW.
    upd.upd_value = 16'h1234;
    upd.upd_valid = 1'b1;
    lz_en = 1'b0;
    run(FRAME);
    run(2 * SLOT + 4);
    chk("pre_reset_digit2_en", digit_en, 4'b0100);
    chk("pre_reset_digit2_num", digit_num, 4'h2);
    do_reset();
    run(FRAME);

    // Random values, random request times, lz_en toggled per frame.
    for (int f = 0; f < 12; f++) begin
      lz_en = 1'($urandom_range(0, 1));
      k = $urandom_range(1, FRAME - 1);
      run(k);
      if (!upd.upd_valid) begin
        upd.upd_value = 16'($urandom);
        if ($urandom_range(0, 3) == 0) upd.upd_value = 16'($urandom_range(0, 255));
        upd.upd_valid = 1'($urandom_range(0, 1));
      end
      run(FRAME - k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
